// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage. Registers EX results and extracts load data
//            from the SRAM read word, holding that word across MEM stalls.
// Revision : 1.0
// ============================================================================
module mem_stage #(
    parameter int EX_TO_MEM_WD = 80,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_BUS    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [65:0]             ex_to_mem1,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [65:0]             mem_to_wb1,
    output logic [37:0]             mem_to_id_bus,
    output logic [65:0]             mem_to_id_2
);

    logic [EX_TO_MEM_WD-1:0] ex_bus_q, ex_bus_d;
    logic [65:0]             hilo_q, hilo_d;
    logic                    fresh_q, fresh_d;
    logic [31:0]             rdata_hold_q, rdata_hold_d;

    logic [31:0] pc;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [3:0]  ram_read;
    logic [1:0]  offset;
    logic [31:0] rdata_eff;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;
    logic [31:0] rf_wdata;
    logic        unused_bits;

    always_comb begin
        ex_bus_d     = ex_bus_q;
        hilo_d       = hilo_q;
        fresh_d      = 1'b0;
        if (!stall[3]) begin
            ex_bus_d = ex_to_mem_bus;
            hilo_d   = ex_to_mem1;
            fresh_d  = 1'b1;
        end else if (!stall[4]) begin
            ex_bus_d = '0;
            hilo_d   = '0;
        end
        // The SRAM word is only valid in the first MEM cycle; keep it for stalls.
        rdata_hold_d = fresh_q ? data_sram_rdata : rdata_hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_bus_q     <= '0;
            hilo_q       <= '0;
            fresh_q      <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            ex_bus_q     <= ex_bus_d;
            hilo_q       <= hilo_d;
            fresh_q      <= fresh_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign pc         = ex_bus_q[79:48];
    assign sel_rf_res = ex_bus_q[42];
    assign rf_we      = ex_bus_q[41];
    assign rf_waddr   = ex_bus_q[40:36];
    assign ex_result  = ex_bus_q[35:4];
    assign ram_read   = ex_bus_q[3:0];
    assign offset     = ex_result[1:0];
    assign rdata_eff  = fresh_q ? data_sram_rdata : rdata_hold_q;

    always_comb begin
        load_byte = rdata_eff[7:0];
        load_half = '0;
        load_val  = '0;
        case (offset)
            2'd0:    load_byte = rdata_eff[7:0];
            2'd1:    load_byte = rdata_eff[15:8];
            2'd2:    load_byte = rdata_eff[23:16];
            default: load_byte = rdata_eff[31:24];
        endcase
        // Odd halfword offsets leave load_half at zero.
        case (offset)
            2'd0:    load_half = rdata_eff[15:0];
            2'd2:    load_half = rdata_eff[31:16];
            default: load_half = '0;
        endcase
        case (ram_read)
            4'b1111: load_val = rdata_eff;
            4'b0001: load_val = {{24{load_byte[7]}}, load_byte};
            4'b0010: load_val = {24'b0, load_byte};
            4'b0011: load_val = {{16{load_half[15]}}, load_half};
            4'b0100: load_val = {16'b0, load_half};
            default: load_val = '0;
        endcase
    end

    assign rf_wdata      = sel_rf_res ? load_val : ex_result;
    assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};
    assign mem_to_wb1    = hilo_q;
    assign mem_to_id_2   = hilo_q;

    assign unused_bits = ^{stall[STALL_BUS-1:5], stall[2:0], ex_bus_q[47:43]};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// Scoreboard bench for mem_stage: directed load/stall/reset cases, then random traffic.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic [79:0] ex_to_mem_bus = '0;
    logic [65:0] ex_to_mem1 = '0;
    logic [31:0] data_sram_rdata = '0;
    logic [69:0] mem_to_wb_bus;
    logic [65:0] mem_to_wb1;
    logic [37:0] mem_to_id_bus;
    logic [65:0] mem_to_id_2;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_to_mem_bus  (ex_to_mem_bus),
        .ex_to_mem1     (ex_to_mem1),
        .data_sram_rdata(data_sram_rdata),
        .mem_to_wb_bus  (mem_to_wb_bus),
        .mem_to_wb1     (mem_to_wb1),
        .mem_to_id_bus  (mem_to_id_bus),
        .mem_to_id_2    (mem_to_id_2)
    );

    typedef struct packed {
        logic [69:0] wb;
        logic [65:0] e1;
        logic [37:0] id;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference state: instruction sitting in MEM and the word it loaded.
    logic [79:0] m_bus  = '0;
    logic [65:0] m_e1   = '0;
    bit          m_fresh = 0;
    logic [31:0] m_word = '0;

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [79:0] mk(input logic [31:0] pc, input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res,
                                       input logic [3:0] rr);
        return {pc, 1'b1, 4'b0000, sel, we, wa, res, rr};
    endfunction

    function automatic logic [31:0] ld(input logic [3:0] rr, input logic [1:0] off,
                                       input logic [31:0] w);
        int b, h;
        bit odd;
        b   = int'((w >> (8 * int'(off))) & 32'hFF);
        odd = (off == 2'd1) || (off == 2'd3);
        h   = (off == 2'd0) ? int'(w & 32'hFFFF) : int'(w >> 16);
        case (rr)
            4'b1111: return w;
            4'b0001: return (b >= 128) ? 32'(b - 256) : 32'(b);
            4'b0010: return 32'(b);
            4'b0011: return odd ? 32'd0 : ((h >= 32768) ? 32'(h - 65536) : 32'(h));
            4'b0100: return odd ? 32'd0 : 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock: update the model for the edge, drive the next inputs and
    // this cycle's SRAM word, then queue the outputs the DUT should now present.
    task automatic cycle(input logic r, input logic [5:0] st, input logic [79:0] bus,
                         input logic [65:0] e1, input logic [31:0] rd);
        exp_t        e;
        logic [31:0] wd;
        @(posedge clk);
        if (rst) begin
            m_bus = '0; m_e1 = '0; m_fresh = 0; m_word = '0;
        end else if (!stall[3]) begin
            m_bus = ex_to_mem_bus; m_e1 = ex_to_mem1; m_fresh = 1;
        end else begin
            m_fresh = 0;
            if (!stall[4]) begin
                m_bus = '0; m_e1 = '0;
            end
        end
        #1;
        rst = r; stall = st; ex_to_mem_bus = bus; ex_to_mem1 = e1; data_sram_rdata = rd;
        if (m_fresh) m_word = rd;
        wd   = m_bus[42] ? ld(m_bus[3:0], m_bus[5:4], m_word) : m_bus[35:4];
        e.wb = {m_bus[79:48], m_bus[41], m_bus[40:36], wd};
        e.e1 = m_e1;
        e.id = {m_bus[41], m_bus[40:36], wd};
        sbq.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("mem_to_wb_bus", 128'(mem_to_wb_bus), 128'(mon_e.wb));
                chk("mem_to_wb1",    128'(mem_to_wb1),    128'(mon_e.e1));
                chk("mem_to_id_bus", 128'(mem_to_id_bus), 128'(mon_e.id));
                chk("mem_to_id_2",   128'(mem_to_id_2),   128'(mon_e.e1));
            end
        end
    end

    initial begin
        logic [3:0]  codes [8];
        logic [65:0] hl;
        logic [79:0] junk;
        codes = '{4'b1111, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0111, 4'b0000};
        hl    = {2'b11, 32'hAAAA_AAAA, 32'h5555_5555};
        junk  = mk(32'h0000_0F00, 1'b1, 1'b1, 5'd31, 32'h0000_0001, 4'b0001);

        cycle(1'b1, 6'b0, '0, '0, '0);
        cycle(1'b1, 6'b0, '0, '0, '0);
        cycle(1'b0, 6'b0, mk(32'h100, 1'b1, 1'b1, 5'd3, 32'h1000_0003, 4'b0001), '0, '0);
        cycle(1'b0, 6'b0, mk(32'h104, 1'b1, 1'b1, 5'd4, 32'h1000_0003, 4'b0010), '0, 32'h80FF_0000);
        @(negedge clk); chk("lb_off3", 128'(mem_to_wb_bus[31:0]), 128'(32'hFFFF_FF80));
        cycle(1'b0, 6'b0, mk(32'h108, 1'b1, 1'b1, 5'd5, 32'h1000_0002, 4'b0011), '0, 32'h80FF_0000);
        @(negedge clk); chk("lbu_off3", 128'(mem_to_wb_bus[31:0]), 128'(32'h0000_0080));
        cycle(1'b0, 6'b0, mk(32'h10C, 1'b1, 1'b1, 5'd6, 32'h1000_0000, 4'b0100), '0, 32'h8001_1234);
        @(negedge clk); chk("lh_off2", 128'(mem_to_wb_bus[31:0]), 128'(32'hFFFF_8001));
        cycle(1'b0, 6'b0, mk(32'h110, 1'b1, 1'b1, 5'd7, 32'h1000_0001, 4'b0011), '0, 32'h8001_1234);
        @(negedge clk); chk("lhu_off0", 128'(mem_to_wb_bus[31:0]), 128'(32'h0000_1234));
        cycle(1'b0, 6'b0, mk(32'h114, 1'b1, 1'b1, 5'd8, 32'h1000_0100, 4'b1111), '0, 32'h8001_1234);
        @(negedge clk); chk("lh_off1", 128'(mem_to_wb_bus[31:0]), 128'(32'h0));
        cycle(1'b0, 6'b011000, junk, '0, 32'h1234_5678);
        @(negedge clk); chk("lw_first", 128'(mem_to_wb_bus[31:0]), 128'(32'h1234_5678));
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 6'b011000, junk, '0, 32'hDEAD_BEEF);
            @(negedge clk); chk("lw_held", 128'(mem_to_wb_bus[31:0]), 128'(32'h1234_5678));
        end
        cycle(1'b0, 6'b001000, junk, '0, 32'hDEAD_BEEF);
        @(negedge clk); chk("lw_held", 128'(mem_to_wb_bus[31:0]), 128'(32'h1234_5678));
        cycle(1'b0, 6'b0, mk(32'h11C, 1'b0, 1'b1, 5'd9, 32'd7, 4'b0000), hl, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("bubble_wb_bus", 128'(mem_to_wb_bus), 128'(0));
        chk("bubble_wb1",    128'(mem_to_wb1),    128'(0));
        chk("bubble_rf_we",  128'(mem_to_id_bus[37]), 128'(0));
        cycle(1'b0, 6'b0, mk(32'h120, 1'b1, 1'b1, 5'd10, 32'h200, 4'b1111), '0, '0);
        @(negedge clk);
        chk("add_wdata", 128'(mem_to_wb_bus[31:0]), 128'(32'd7));
        chk("hilo_wb1",  128'(mem_to_wb1),  128'(hl));
        chk("hilo_id_2", 128'(mem_to_id_2), 128'(hl));
        cycle(1'b0, 6'b011000, '0, '0, 32'h1111_1111);
        @(negedge clk); chk("lw_before_rst", 128'(mem_to_wb_bus[31:0]), 128'(32'h1111_1111));
        cycle(1'b1, 6'b011000, '0, '0, 32'h2222_2222);
        @(negedge clk); chk("lw_held_rst", 128'(mem_to_wb_bus[31:0]), 128'(32'h1111_1111));
        cycle(1'b0, 6'b0, mk(32'h124, 1'b1, 1'b1, 5'd3, 32'h1000_0003, 4'b0001), '0, 32'h3333_3333);
        @(negedge clk);
        chk("rst_wb_bus", 128'(mem_to_wb_bus), 128'(0));
        chk("rst_wb1",    128'(mem_to_wb1),    128'(0));
        chk("rst_id_bus", 128'(mem_to_id_bus), 128'(0));
        chk("rst_id_2",   128'(mem_to_id_2),   128'(0));
        cycle(1'b0, 6'b0, '0, '0, 32'h80FF_0000);
        @(negedge clk); chk("lb_after_rst", 128'(mem_to_wb_bus[31:0]), 128'(32'hFFFF_FF80));

        for (int i = 0; i < 2000; i++) begin
            logic [5:0]  st;
            logic [79:0] bus;
            logic [65:0] e1;
            st    = 6'($urandom);
            st[3] = ($urandom_range(0, 99) < 30);
            st[4] = 1'($urandom_range(0, 1));
            bus   = mk($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)), $urandom, codes[$urandom_range(0, 7)]);
            e1    = {2'($urandom_range(0, 3)), $urandom, $urandom};
            cycle(($urandom_range(0, 99) < 3), st, bus, e1, $urandom);
        end
        cycle(1'b0, 6'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 128'(sbq.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
